// File: rtl/regfile_seq_ctrl.sv
// regfile_seq_ctrl: multi-cycle controller for the 8x16 register-file datapath.
// Takes one instruction per start handshake and sequences the register file,
// operand registers A/B, the C result register and the status register.
// Optional build macro CTRL_HALT_EN: opcode 111 becomes a terminal HALT that
// only reset_n can leave. Without it, opcode 111 is reported as undefined.
module regfile_seq_ctrl #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          s,
    input  logic [DW-1:0] instr,
    output logic          w,
    output logic          err,
    output logic [RW-1:0] readnum,
    output logic [RW-1:0] writenum,
    output logic          write,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    vsel,
    output logic [1:0]    shift,
    output logic [1:0]    alu_op,
    output logic [DW-1:0] sximm8
);

    typedef enum logic [3:0] {
        WAIT   = 4'd0,
        DECODE = 4'd1,
        GETA   = 4'd2,
        GETB   = 4'd3,
        EXEC   = 4'd4,
        WR_REG = 4'd5,
        WR_IMM = 4'd6,
        STAT   = 4'd7
`ifdef CTRL_HALT_EN
        ,
        HALT   = 4'd8
`endif
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] ir;

    logic [2:0] opcode;
    logic [1:0] op;
    logic       is_mov_imm;
    logic       is_mov_reg;
    logic       is_alu;
    logic       is_cmp;
    logic       is_mvn;
    logic       is_halt;
    logic       is_defined;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];

    // Instruction class decode from the registered instruction
    always_comb begin
        is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
        is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
        is_alu     = (opcode == 3'b101);
        is_cmp     = is_alu && (op == 2'b01);
        is_mvn     = is_alu && (op == 2'b11);
`ifdef CTRL_HALT_EN
        is_halt    = (opcode == 3'b111);
`else
        is_halt    = 1'b0;
`endif
        is_defined = is_mov_imm | is_mov_reg | is_alu | is_halt;
    end

    // State and instruction registers; the instruction is captured only on acceptance
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= WAIT;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == WAIT && s)
                ir <= instr;
        end
    end

    // Next-state sequencing for each instruction path
    always_comb begin
        state_next = state;
        case (state)
            WAIT:    if (s) state_next = DECODE;
            DECODE: begin
                if (is_mov_imm)
                    state_next = WR_IMM;
                else if (is_mov_reg || is_mvn)
                    state_next = GETB;
                else if (is_alu)
                    state_next = GETA;
`ifdef CTRL_HALT_EN
                else if (is_halt)
                    state_next = HALT;
`endif
                else
                    state_next = WAIT;
            end
            GETA:    state_next = GETB;
            GETB:    state_next = is_cmp ? STAT : EXEC;
            EXEC:    state_next = WR_REG;
            WR_REG:  state_next = WAIT;
            WR_IMM:  state_next = WAIT;
            STAT:    state_next = WAIT;
`ifdef CTRL_HALT_EN
            HALT:    state_next = HALT;
`endif
            default: state_next = WAIT;
        endcase
    end

    // Moore output decode from state and the registered instruction fields
    always_comb begin
        w        = 1'b0;
        err      = 1'b0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 2'b00;
        case (state)
            WAIT:   w = 1'b1;
            DECODE: err = !is_defined;
            GETA: begin
                readnum = ir[10:8];
                loada   = 1'b1;
            end
            GETB: begin
                readnum = ir[2:0];
                loadb   = 1'b1;
            end
            EXEC: begin
                loadc = 1'b1;
                asel  = is_mov_reg | is_mvn;
            end
            WR_REG: begin
                writenum = ir[7:5];
                vsel     = 2'b00;
                write    = 1'b1;
            end
            WR_IMM: begin
                writenum = ir[10:8];
                vsel     = 2'b01;
                write    = 1'b1;
            end
            STAT:   loads = 1'b1;
            default: ;
        endcase
    end

    // Field pass-through used by the datapath regardless of state
    always_comb begin
        shift  = ir[4:3];
        alu_op = ir[12:11];
        sximm8 = {{(DW-8){ir[7]}}, ir[7:0]};
    end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Directed testbench for regfile_seq_ctrl. Expected values are hand-derived
// from the instruction encodings. The HALT steps are built when CTRL_HALT_EN
// is defined; otherwise opcode 111 is checked as undefined.
module tb_regfile_seq_ctrl;

    logic        clk;
    logic        reset_n;
    logic        s;
    logic [15:0] instr;
    logic        w;
    logic        err;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  alu_op;
    logic [15:0] sximm8;

    int checks = 0;
    int errors = 0;

    regfile_seq_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s        (s),
        .instr    (instr),
        .w        (w),
        .err      (err),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .shift    (shift),
        .alu_op   (alu_op),
        .sximm8   (sximm8)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst_n_v, input logic s_v, input logic [15:0] instr_v);
        reset_n = rst_n_v;
        s       = s_v;
        instr   = instr_v;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        int n_loads;
        int n_write;
        int n_loadc;
        int n_err;
        int n_w;

        // Reset held with s high: nothing may be accepted
        applyStimulus(1'b0, 1'b1, 16'hD007);
        tick();
        tick();
        checkOutput("rst_w", w, 1);
        checkOutput("rst_write", write, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_readnum", readnum, 0);
        checkOutput("rst_vsel", vsel, 0);
        applyStimulus(1'b1, 1'b0, 16'hD007);
        tick();
        checkOutput("rst_release_w", w, 1);

        // MOV R0,#7
        applyStimulus(1'b1, 1'b1, 16'hD007);
        tick();
        s = 1'b0;
        checkOutput("movi0_dec_w", w, 0);
        checkOutput("movi0_dec_write", write, 0);
        tick();
        checkOutput("movi0_write", write, 1);
        checkOutput("movi0_writenum", writenum, 0);
        checkOutput("movi0_vsel", vsel, 2'b01);
        checkOutput("movi0_sximm8", sximm8, 16'h0007);
        tick();
        checkOutput("movi0_done_w", w, 1);
        checkOutput("movi0_done_write", write, 0);

        // MOV R1,#-2
        applyStimulus(1'b1, 1'b1, 16'hD1FE);
        tick();
        s = 1'b0;
        tick();
        checkOutput("movi1_write", write, 1);
        checkOutput("movi1_writenum", writenum, 1);
        checkOutput("movi1_sximm8", sximm8, 16'hFFFE);
        tick();
        checkOutput("movi1_done_w", w, 1);

        // ADD R2,R1,R0
        applyStimulus(1'b1, 1'b1, 16'hA140);
        tick();
        s = 1'b0;
        checkOutput("add_dec_loada", loada, 0);
        checkOutput("add_dec_err", err, 0);
        tick();
        checkOutput("add_geta_readnum", readnum, 1);
        checkOutput("add_geta_loada", loada, 1);
        checkOutput("add_geta_loadb", loadb, 0);
        tick();
        checkOutput("add_getb_readnum", readnum, 0);
        checkOutput("add_getb_loadb", loadb, 1);
        checkOutput("add_getb_loada", loada, 0);
        tick();
        checkOutput("add_exec_loadc", loadc, 1);
        checkOutput("add_exec_asel", asel, 0);
        checkOutput("add_exec_write", write, 0);
        tick();
        checkOutput("add_wr_write", write, 1);
        checkOutput("add_wr_writenum", writenum, 2);
        checkOutput("add_wr_vsel", vsel, 0);
        checkOutput("add_wr_w", w, 0);
        tick();
        checkOutput("add_done_w", w, 1);

        // CMP R0,R1: status load once, no C load or write
        applyStimulus(1'b1, 1'b1, 16'hA801);
        tick();
        s = 1'b0;
        n_loads = 0;
        n_write = 0;
        n_loadc = 0;
        for (int i = 0; i < 4; i++) begin
            if (loads) n_loads++;
            if (write) n_write++;
            if (loadc) n_loadc++;
            tick();
        end
        checkOutput("cmp_loads_count", 16'(n_loads), 1);
        checkOutput("cmp_write_count", 16'(n_write), 0);
        checkOutput("cmp_loadc_count", 16'(n_loadc), 0);
        checkOutput("cmp_done_w", w, 1);

        // MVN R3,R0
        applyStimulus(1'b1, 1'b1, 16'hB860);
        tick();
        s = 1'b0;
        checkOutput("mvn_alu_op", alu_op, 2'b11);
        tick();
        checkOutput("mvn_getb_loadb", loadb, 1);
        checkOutput("mvn_getb_loada", loada, 0);
        tick();
        checkOutput("mvn_exec_asel", asel, 1);
        checkOutput("mvn_exec_loadc", loadc, 1);
        tick();
        checkOutput("mvn_wr_writenum", writenum, 3);
        checkOutput("mvn_wr_write", write, 1);
        tick();
        checkOutput("mvn_done_w", w, 1);

        // MOV R5,R1,LSL-style shift 01
        applyStimulus(1'b1, 1'b1, 16'hC0A9);
        tick();
        s = 1'b0;
        checkOutput("movr_shift", shift, 2'b01);
        tick();
        checkOutput("movr_getb_readnum", readnum, 1);
        checkOutput("movr_getb_loadb", loadb, 1);
        tick();
        checkOutput("movr_exec_asel", asel, 1);
        tick();
        checkOutput("movr_wr_writenum", writenum, 5);
        tick();
        checkOutput("movr_done_w", w, 1);

        // Undefined opcode 000
        applyStimulus(1'b1, 1'b1, 16'h0000);
        tick();
        s = 1'b0;
        checkOutput("undef_err", err, 1);
        checkOutput("undef_enables", {loada, loadb, loadc, loads, write}, 0);
        tick();
        checkOutput("undef_err_clear", err, 0);
        checkOutput("undef_back_w", w, 1);

        // Undefined op within opcode 110
        applyStimulus(1'b1, 1'b1, 16'hC800);
        tick();
        s = 1'b0;
        checkOutput("undef110_err", err, 1);
        tick();
        checkOutput("undef110_back_w", w, 1);

`ifdef CTRL_HALT_EN
        // HALT: terminal until reset, s ignored
        applyStimulus(1'b1, 1'b1, 16'hE000);
        tick();
        instr = 16'hD007;
        n_w = 0;
        n_write = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (w) n_w++;
            if (write) n_write++;
        end
        checkOutput("halt_w_count", 16'(n_w), 0);
        checkOutput("halt_write_count", 16'(n_write), 0);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        tick();
        checkOutput("halt_reset_w", w, 1);
        reset_n = 1'b1;
        tick();
`else
        // Opcode 111 is undefined in this build
        applyStimulus(1'b1, 1'b1, 16'hE000);
        tick();
        s = 1'b0;
        checkOutput("op111_err", err, 1);
        n_err = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (err) n_err++;
        end
        checkOutput("op111_err_once", 16'(n_err), 0);
        checkOutput("op111_back_w", w, 1);
`endif

        // Reset during GETB of ADD aborts with no write
        applyStimulus(1'b1, 1'b1, 16'hA140);
        tick();
        s = 1'b0;
        tick();
        tick();
        checkOutput("abort_in_getb", loadb, 1);
        reset_n = 1'b0;
        tick();
        checkOutput("abort_w", w, 1);
        reset_n = 1'b1;
        n_write = 0;
        for (int i = 0; i < 4; i++) begin
            if (write) n_write++;
            tick();
        end
        checkOutput("abort_write_count", 16'(n_write), 0);
        checkOutput("abort_idle_w", w, 1);

        // s held high: two MOV immediates back to back, one WAIT cycle between
        applyStimulus(1'b1, 1'b1, 16'hD007);
        tick();
        instr = 16'hD102;
        tick();
        checkOutput("b2b_wr0_write", write, 1);
        checkOutput("b2b_wr0_writenum", writenum, 0);
        checkOutput("b2b_wr0_sximm8", sximm8, 16'h0007);
        tick();
        checkOutput("b2b_wait_w", w, 1);
        checkOutput("b2b_wait_write", write, 0);
        tick();
        checkOutput("b2b_dec_w", w, 0);
        s = 1'b0;
        tick();
        checkOutput("b2b_wr1_write", write, 1);
        checkOutput("b2b_wr1_writenum", writenum, 1);
        checkOutput("b2b_wr1_sximm8", sximm8, 16'h0002);
        tick();
        checkOutput("b2b_done_w", w, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
